adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Sequencer for the 8-bit parallel ADC front end. It generates the ADC sample clock from the 50 MHz system clock with a phase-accumulator NCO and discards the ADC pipeline latency after start. It then optionally waits for a rising level-crossing trigger and writes a frame of 2**ADDR_W samples into the downstream sample RAM, which the spectral/separation stage reads. It handshakes with the host via start/abort/busy/done.

Parameters:
ADDR_W, 10, frame length N = 2**ADDR_W samples; also the RAM address width.
FTW_RST, 439804651, NCO tuning word after reset (5.12 MHz at 50 MHz clk).
ADC_LAT, 3, ADC pipeline depth; samples discarded after start before arming.
TRIG_TO, 4096, samples to wait in ARM before auto-trigger.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a capture from IDLE or DONE
abort  in  1  one-cycle pulse; returns to IDLE from any state
ftw  in  32  NCO tuning word; loaded only in IDLE/DONE when ftw_ld=1
ftw_ld  in  1  load strobe for ftw
trig_en  in  1  1 = level-crossing trigger, 0 = free-run capture
trig_level  in  8  unsigned trigger threshold
ad_data  in  8  ADC parallel output, unsigned offset-binary
ad_clk  out  1  ADC sample clock
wr_en  out  1  sample RAM write strobe
wr_addr  out  ADDR_W  sample RAM address
wr_data  out  8  sample value
busy  out  1  high in FLUSH/ARM/CAPTURE
done  out  1  high in DONE
trig_timeout  out  1  frame was auto-triggered; valid while done=1

Behaviour:
- Reset values: acc=0, ftw_reg=FTW_RST, ad_clk=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, trig_timeout=0, state IDLE.
- NCO: acc <= acc + ftw_reg every clk, wrapping mod 2^32. ad_clk = acc[31], a registered bit. It runs continuously in all states, with f = ftw_reg*50e6/2^32. ftw_reg updates on ftw_ld only in IDLE/DONE; ftw_ld is ignored elsewhere.
- tick = acc[31] & ~msb_d, where msb_d is acc[31] delayed one clk. On each tick, ad_data is registered into smp and the previous smp is kept in smp_prev.
- IDLE: start -> FLUSH with flush_cnt=0.
- FLUSH: count ticks. After ADC_LAT ticks, go to ARM if trig_en, else CAPTURE.
- ARM: on each tick, check the crossing condition (smp_prev < trig_level) && (smp >= trig_level), using the newly registered sample.
  - If the crossing holds: go to CAPTURE; that sample is written at address 0.
  - If TRIG_TO ticks pass with no crossing: set trig_timeout=1, go to CAPTURE; the timeout sample is written at address 0.
  - The first tick in ARM compares against the last FLUSH sample.
- CAPTURE: each tick writes one sample. wr_en is high for exactly one clk, one clk after the tick; wr_data=smp. wr_addr runs 0..N-1 and holds its value between writes. After the write at N-1, go to DONE on the next clk.
- DONE: done=1, busy=0. A start here clears done and trig_timeout and goes to FLUSH. A start in FLUSH/ARM/CAPTURE is ignored.
- abort has priority over start and over tick in the same cycle. It goes to IDLE next clk and clears busy/done/trig_timeout and wr_addr. A write already issued stays issued. The NCO is unaffected.
- reset mid-capture: all outputs return to reset values next clk; the NCO restarts from 0 with FTW_RST.
- ftw=0 stops ad_clk at its current level: no ticks, so the FSM stalls in its current state until abort. Legal, not an error.
- Comparisons are unsigned 8-bit. Counters saturate/clear only as stated; wr_addr never exceeds N-1.

Test Plan:
1. FTW=2^30 (clk/4), trig_en=0, ADDR_W=4, ramp ad_data = tick index -> ad_clk period 4 clk. wr_en is high 16 times, 4 clk apart. wr_data=3..18 (first 3 discarded, ADC_LAT=3) at addr 0..15. done rises 1 clk after the last write.
2. Default FTW, 50 kHz+100 kHz sine sum (offset 128, amp 63.5 each), trig_en=1, trig_level=128 -> wr_data[0]≥128 and the previous sample was <128. trig_timeout=0, and 1024 writes occur.
3. trig_en=1, constant ad_data=0x40, trig_level=0x80, TRIG_TO=8 -> auto-trigger after 8 ticks in ARM. trig_timeout=1 at done; all wr_data=0x40.
4. abort and start in the same cycle mid-CAPTURE (after 5 writes) -> IDLE next clk, busy=0, no further wr_en. A later start gives a full frame beginning at addr 0.
5. ftw_ld during CAPTURE with ftw=2^29 -> period is unchanged. ftw_ld in DONE -> ad_clk period becomes 8 clk.
6. reset asserted mid-ARM -> next clk all outputs are at reset values, ad_clk=0, and start is required to resume.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_capture_ctrl : NCO-clocked ADC sequencer with level trigger and frame  |
// | writer into the downstream sample RAM.                      Revision: 1.0  |
// +----------------------------------------------------------------------------+
module adc_capture_ctrl #(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] FTW_RST = 32'd439804651,
  parameter int          ADC_LAT = 3,
  parameter int          TRIG_TO = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       ftw,
  input  logic              ftw_ld,
  input  logic              trig_en,
  input  logic [7:0]        trig_level,
  input  logic [7:0]        ad_data,
  output logic              ad_clk,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              trig_timeout
);

  localparam int FL_W = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;
  localparam int TO_W = (TRIG_TO > 1) ? $clog2(TRIG_TO) : 1;

  localparam logic [FL_W-1:0]   c_fl_last   = FL_W'(ADC_LAT - 1);
  localparam logic [FL_W-1:0]   c_fl_one    = FL_W'(1);
  localparam logic [TO_W-1:0]   c_to_last   = TO_W'(TRIG_TO - 1);
  localparam logic [TO_W-1:0]   c_to_one    = TO_W'(1);
  localparam logic [ADDR_W:0]   c_n         = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   c_idx_one   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_addr_last = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_ARM     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic [31:0]       r_acc;
  logic [31:0]       r_ftw;
  logic              r_msb_d;
  logic [7:0]        r_smp;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [TO_W-1:0]   r_arm_cnt;
  logic [ADDR_W:0]   r_idx;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_trig_to;

  logic              w_tick;
  logic              w_cross;

  assign w_tick  = r_acc[31] & ~r_msb_d;
  // r_smp still holds the previous sample; ad_data is the one being registered
  assign w_cross = (r_smp < trig_level) && (ad_data >= trig_level);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_ftw       <= FTW_RST;
      r_msb_d     <= 1'b0;
      r_smp       <= '0;
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_arm_cnt   <= '0;
      r_idx       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trig_to   <= 1'b0;
    end else begin
      r_acc   <= r_acc + r_ftw;
      r_msb_d <= r_acc[31];
      if (w_tick) r_smp <= ad_data;
      r_wr_en <= 1'b0;

      if (abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_trig_to <= 1'b0;
        r_wr_addr <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (ftw_ld) r_ftw <= ftw;
            if (start) begin
              r_state     <= S_FLUSH;
              r_flush_cnt <= '0;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_trig_to   <= 1'b0;
            end
          end
          S_FLUSH: begin
            if (w_tick) begin
              if (r_flush_cnt == c_fl_last) begin
                r_state   <= trig_en ? S_ARM : S_CAPTURE;
                r_arm_cnt <= '0;
                r_idx     <= '0;
              end else begin
                r_flush_cnt <= r_flush_cnt + c_fl_one;
              end
            end
          end
          S_ARM: begin
            // The triggering (or timed-out) sample itself becomes address 0
            if (w_tick) begin
              if (w_cross || (r_arm_cnt == c_to_last)) begin
                r_state   <= S_CAPTURE;
                r_trig_to <= ~w_cross;
                r_wr_en   <= 1'b1;
                r_wr_addr <= '0;
                r_wr_data <= ad_data;
                r_idx     <= c_idx_one;
              end else begin
                r_arm_cnt <= r_arm_cnt + c_to_one;
              end
            end
          end
          S_CAPTURE: begin
            if (r_wr_en && (r_wr_addr == c_addr_last)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_tick && (r_idx < c_n)) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_idx[ADDR_W-1:0];
              r_wr_data <= ad_data;
              r_idx     <= r_idx + c_idx_one;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ad_clk       = r_acc[31];
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign trig_timeout = r_trig_to;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adc_capture_ctrl : randomized self-checking bench for adc_capture_ctrl. |
// |                                                             Revision: 1.0  |
// +----------------------------------------------------------------------------+
module tb_adc_capture_ctrl;

  localparam int          ADDR_W  = 4;
  localparam int          N       = 16;
  localparam int          ADC_LAT = 3;
  localparam int          TRIG_TO = 8;
  localparam logic [31:0] FTW_RST = 32'd439804651;

  logic              clk = 1'b0;
  logic              reset = 1'b1, start = 1'b0, abort = 1'b0, ftw_ld = 1'b0, trig_en = 1'b0;
  logic [31:0]       ftw = '0;
  logic [7:0]        trig_level = '0, ad_data = '0;
  logic              ad_clk, wr_en, busy, done, trig_timeout;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  adc_capture_ctrl #(.ADDR_W(ADDR_W), .FTW_RST(FTW_RST), .ADC_LAT(ADC_LAT), .TRIG_TO(TRIG_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ftw(ftw), .ftw_ld(ftw_ld),
    .trig_en(trig_en), .trig_level(trig_level), .ad_data(ad_data), .ad_clk(ad_clk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .trig_timeout(trig_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0, done_cyc = -1;
  logic done_prev = 1'b0;
  logic [ADDR_W-1:0] wq_addr[$];
  logic [7:0]        wq_data[$];
  int                wq_cyc[$];
  logic [7:0]        smp_q[$];

  logic [31:0] m_acc, m_ftw;
  logic        m_msb_d;
  bit          m_rec = 1'b0, m_active = 1'b0;
  int          dmode = 0, tri_step = 1;
  logic [7:0]  dconst = '0;
  logic [8:0]  tri_ph = '0;

  // ADC data source: random, constant or triangle wave
  always @(negedge clk) begin
    case (dmode)
      0:       ad_data = 8'($urandom);
      1:       ad_data = dconst;
      default: begin
        tri_ph  = tri_ph + 9'(tri_step);
        ad_data = tri_ph[8] ? ~tri_ph[7:0] : tri_ph[7:0];
      end
    endcase
  end

  // Reference: NCO arithmetic gives the sample instants; every sample taken since start is kept
  always @(posedge clk) begin
    if (reset) begin
      m_acc   <= '0;
      m_msb_d <= 1'b0;
      m_ftw   <= FTW_RST;
    end else begin
      m_acc   <= m_acc + m_ftw;
      m_msb_d <= m_acc[31];
      if (ftw_ld && !m_active) m_ftw <= ftw;
      if (m_rec && !start && m_acc[31] && !m_msb_d) smp_q.push_back(ad_data);
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame start index into the sample list, from the flush/trigger/timeout rules
  function automatic void model_frame(input bit trig, input logic [7:0] lvl,
                                      output int first, output bit to);
    int j;
    first = ADC_LAT;
    to    = 1'b0;
    if (trig) begin
      to    = 1'b1;
      first = ADC_LAT + TRIG_TO - 1;
      for (int k = 0; k < TRIG_TO; k++) begin
        j = ADC_LAT + k;
        if (smp_q[j-1] < lvl && smp_q[j] >= lvl) begin
          first = j;
          to    = 1'b0;
          break;
        end
      end
    end
  endfunction

  task automatic tick_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_ftw(input logic [31:0] v);
    @(negedge clk); ftw = v; ftw_ld = 1'b1;
    @(negedge clk); ftw_ld = 1'b0;
  endtask

  task automatic begin_capture();
    @(negedge clk);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); smp_q.delete();
    done_cyc = -1;
    start = 1'b1; m_rec = 1'b1; m_active = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    m_rec = 1'b0; m_active = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_clk(3);
    n_cmp++; if (ad_clk !== 1'b0)       begin n_err++; $display("FAIL reset_ad_clk: got %b want 0", ad_clk); end
    n_cmp++; if (wr_en !== 1'b0)        begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== '0)        begin n_err++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    n_cmp++; if (wr_data !== '0)        begin n_err++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)         begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (trig_timeout !== 1'b0) begin n_err++; $display("FAIL reset_trig_timeout: got %b want 0", trig_timeout); end
    reset = 1'b0;
  endtask

  task automatic test_freerun();
    bit ok; int first; bit to;
    load_ftw(32'h4000_0000);
    trig_en = 1'b0; dmode = 0;
    begin_capture();
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL freerun_done: done=%b want 1 within bound", done); end
    model_frame(1'b0, 8'h00, first, to);
    n_cmp++; if (wq_data.size() != N) begin n_err++; $display("FAIL freerun_count: got %0d want %0d", wq_data.size(), N); end
    for (int i = 0; i < N && i < wq_data.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== smp_q[first+i]) begin
        n_err++;
        $display("FAIL freerun_wr[%0d]: got addr %0d data %0h want addr %0d data %0h", i, wq_addr[i], wq_data[i], i, smp_q[first+i]);
      end
    end
    for (int i = 1; i < wq_cyc.size(); i++) begin
      n_cmp++;
      if (wq_cyc[i] - wq_cyc[i-1] != 4) begin n_err++; $display("FAIL freerun_spacing[%0d]: got %0d want 4", i, wq_cyc[i] - wq_cyc[i-1]); end
    end
    n_cmp++;
    if (wq_cyc.size() == 0 || done_cyc != wq_cyc[wq_cyc.size()-1] + 1) begin
      n_err++; $display("FAIL freerun_done_latency: done cycle %0d, last write cycle + 1 required", done_cyc);
    end
    n_cmp++; if (busy !== 1'b0 || trig_timeout !== 1'b0) begin n_err++; $display("FAIL freerun_flags: busy %b trig_timeout %b want 0 0", busy, trig_timeout); end
  endtask

  task automatic test_trigger();
    bit ok; int first; bit to; logic [7:0] lvl; logic [31:0] fv;
    for (int it = 0; it < 3; it++) begin
      lvl      = 8'($urandom_range(32, 224));
      tri_step = $urandom_range(1, 6);
      fv       = (it == 0) ? FTW_RST : 32'($urandom_range(32'h1000_0000, 32'h4000_0000));
      dmode = 2; trig_en = 1'b1; trig_level = lvl;
      load_ftw(fv);
      begin_capture();
      wait_done(3000, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL trig_done[%0d]: done=%b want 1 within bound", it, done); end
      model_frame(1'b1, lvl, first, to);
      n_cmp++; if (trig_timeout !== to) begin n_err++; $display("FAIL trig_timeout[%0d]: got %b want %b", it, trig_timeout, to); end
      n_cmp++; if (wq_data.size() != N) begin n_err++; $display("FAIL trig_count[%0d]: got %0d want %0d", it, wq_data.size(), N); end
      for (int i = 0; i < N && i < wq_data.size(); i++) begin
        n_cmp++;
        if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== smp_q[first+i]) begin
          n_err++;
          $display("FAIL trig_wr[%0d][%0d]: got addr %0d data %0h want addr %0d data %0h", it, i, wq_addr[i], wq_data[i], i, smp_q[first+i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    dmode = 1; dconst = 8'h40; trig_level = 8'h80; trig_en = 1'b1;
    load_ftw(32'h4000_0000);
    begin_capture();
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL timeout_done: done=%b want 1 within bound", done); end
    n_cmp++; if (trig_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", trig_timeout); end
    n_cmp++; if (wq_data.size() != N) begin n_err++; $display("FAIL timeout_count: got %0d want %0d", wq_data.size(), N); end
    for (int i = 0; i < N && i < wq_data.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== 8'h40) begin
        n_err++; $display("FAIL timeout_wr[%0d]: got addr %0d data %0h want addr %0d data 40", i, wq_addr[i], wq_data[i], i);
      end
    end
  endtask

  task automatic test_abort();
    bit ok; int first; bit to; int nw;
    dmode = 0; trig_en = 1'b0;
    load_ftw(32'h4000_0000);
    begin_capture();
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || trig_timeout !== 1'b0) begin
      n_err++; $display("FAIL restart_flags: busy %b done %b trig_timeout %b want 1 0 0", busy, done, trig_timeout);
    end
    for (int k = 0; k < 400 && wq_data.size() < 5; k++) @(negedge clk);
    n_cmp++; if (wq_data.size() != 5) begin n_err++; $display("FAIL abort_pre_writes: got %0d want 5", wq_data.size()); end
    abort = 1'b1; start = 1'b1; m_rec = 1'b0; m_active = 1'b0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || wr_addr !== '0 || trig_timeout !== 1'b0) begin
      n_err++; $display("FAIL abort_state: busy %b done %b wr_addr %0d trig_timeout %b want 0 0 0 0", busy, done, wr_addr, trig_timeout);
    end
    nw = wq_data.size();
    tick_clk(60);
    n_cmp++; if (wq_data.size() != nw || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: writes %0d busy %b want %0d 0", wq_data.size(), busy, nw);
    end
    begin_capture();
    wait_done(1000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_resume_done: done=%b want 1 within bound", done); end
    model_frame(1'b0, 8'h00, first, to);
    n_cmp++; if (wq_data.size() != N) begin n_err++; $display("FAIL abort_resume_count: got %0d want %0d", wq_data.size(), N); end
    for (int i = 0; i < N && i < wq_data.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== smp_q[first+i]) begin
        n_err++;
        $display("FAIL abort_resume_wr[%0d]: got addr %0d data %0h want addr %0d data %0h", i, wq_addr[i], wq_data[i], i, smp_q[first+i]);
      end
    end
  endtask

  task automatic test_ftw_ld();
    bit ok; int first; bit to; int bad; int rises[$]; logic prev;
    dmode = 0; trig_en = 1'b0;
    load_ftw(32'h4000_0000);
    begin_capture();
    for (int k = 0; k < 400 && wq_data.size() < 3; k++) @(negedge clk);
    ftw = 32'h2000_0000; ftw_ld = 1'b1;
    @(negedge clk); ftw_ld = 1'b0;
    wait_done(1000, ok);
    n_cmp++; if (!ok || wq_data.size() != N) begin n_err++; $display("FAIL ftwcap_frame: done %b writes %0d want 1 %0d", ok, wq_data.size(), N); end
    bad = 0;
    for (int i = 1; i < wq_cyc.size(); i++) if (wq_cyc[i] - wq_cyc[i-1] != 4) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ftwcap_spacing: got %0d spacings not 4, want 0", bad); end
    model_frame(1'b0, 8'h00, first, to);
    bad = 0;
    for (int i = 0; i < wq_data.size() && i < N; i++) if (wq_data[i] !== smp_q[first+i]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ftwcap_data: got %0d wrong samples, want 0", bad); end
    load_ftw(32'h2000_0000);
    prev = ad_clk;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ad_clk && !prev) rises.push_back(k);
      prev = ad_clk;
    end
    n_cmp++; if (rises.size() < 3 || rises[1] - rises[0] != 8) begin n_err++; $display("FAIL done_ftw_period_a: got %0d rises, want period 8", rises.size()); end
    n_cmp++; if (rises.size() < 3 || rises[2] - rises[1] != 8) begin n_err++; $display("FAIL done_ftw_period_b: got %0d rises, want period 8", rises.size()); end
  endtask

  task automatic test_ftw_zero();
    logic lvl; bit stuck;
    load_ftw(32'h0000_0000);
    trig_en = 1'b0;
    begin_capture();
    lvl = ad_clk; stuck = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ad_clk !== lvl) stuck = 1'b0;
    end
    n_cmp++; if (!stuck) begin n_err++; $display("FAIL ftw0_ad_clk: ad_clk toggled, want held at %b", lvl); end
    n_cmp++; if (busy !== 1'b1 || wq_data.size() != 0) begin
      n_err++; $display("FAIL ftw0_stall: busy %b writes %0d want 1 0", busy, wq_data.size());
    end
    abort = 1'b1; m_rec = 1'b0; m_active = 1'b0;
    @(negedge clk); abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL ftw0_abort: busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_arm();
    bit ok; int first; bit to; int bad;
    load_ftw(32'h4000_0000);
    trig_en = 1'b1; dmode = 1; dconst = 8'h00; trig_level = 8'hFF;
    begin_capture();
    tick_clk(22);
    n_cmp++; if (busy !== 1'b1 || wq_data.size() != 0) begin
      n_err++; $display("FAIL arm_waiting: busy %b writes %0d want 1 0", busy, wq_data.size());
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; m_rec = 1'b0; m_active = 1'b0;
    n_cmp++; if (ad_clk !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      n_err++; $display("FAIL midreset_data: ad_clk %b wr_en %b wr_addr %0d wr_data %0h want 0 0 0 0", ad_clk, wr_en, wr_addr, wr_data);
    end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || trig_timeout !== 1'b0) begin
      n_err++; $display("FAIL midreset_flags: busy %b done %b trig_timeout %b want 0 0 0", busy, done, trig_timeout);
    end
    tick_clk(50);
    n_cmp++; if (busy !== 1'b0 || wq_data.size() != 0) begin
      n_err++; $display("FAIL midreset_idle: busy %b writes %0d want 0 0", busy, wq_data.size());
    end
    trig_en = 1'b0; dmode = 0;
    begin_capture();
    wait_done(1000, ok);
    model_frame(1'b0, 8'h00, first, to);
    bad = 0;
    for (int i = 0; i < wq_data.size() && i < N; i++)
      if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== smp_q[first+i]) bad++;
    n_cmp++; if (!ok || wq_data.size() != N || bad != 0) begin
      n_err++; $display("FAIL midreset_resume: done %b writes %0d wrong %0d want 1 %0d 0", ok, wq_data.size(), bad, N);
    end
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_trigger();
    test_timeout();
    test_abort();
    test_ftw_ld();
    test_ftw_zero();
    test_reset_mid_arm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
